// File: rtl/sd_sector_arbiter.sv
// rtl/sd_sector_arbiter.sv - round-robin arbiter sharing one SD sector channel among NREQ requesters
// Optional abort of unanswered transactions: define SD_ARB_TIMEOUT_EN.
module sd_sector_arbiter #(
  parameter int          NREQ    = 2,
  parameter int          LBA_W   = 32,
  parameter logic [23:0] TIMEOUT = 24'd5000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_rd,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*LBA_W-1:0]    req_lba,
  input  logic [NREQ*8-1:0]        req_din,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  gnt_idx,
  output logic [NREQ-1:0]          buff_we,
  output logic [LBA_W-1:0]         sd_lba,
  output logic                     sd_rd,
  output logic                     sd_wr,
  input  logic                     sd_ack,
  input  logic                     sd_buff_wr,
  output logic [7:0]               sd_buff_din
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE, S_GAP} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic          found;
  logic          tmo;

  // Scan starts just after the last served requester, so it gets lowest priority.
  always_comb begin
    int j;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && (req_rd[j] || req_wr[j])) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] cnt;
  logic        abort;

  assign tmo = (state == S_ISSUE || state == S_XFER) && (cnt == TIMEOUT - 24'd1);
  assign err = (state == S_DONE) && abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      abort <= 1'b0;
    end else begin
      if (state == S_IDLE)
        cnt <= '0;
      else if (state == S_ISSUE || state == S_XFER)
        cnt <= cnt + 24'd1;
      if (tmo)
        abort <= 1'b1;
      else if (state == S_GAP)
        abort <= 1'b0;
    end
  end
`else
  wire unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!sd_ack && found) state_next = S_ISSUE;
      S_ISSUE: if (tmo) state_next = S_DONE;
               else if (sd_ack) state_next = S_XFER;
      S_XFER:  if (tmo || !sd_ack) state_next = S_DONE;
      S_DONE:  state_next = S_GAP;
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= IW'(NREQ - 1);
      gnt_idx <= '0;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (!sd_ack && found) begin
          gnt_idx <= pick;
          sd_lba  <= req_lba[int'(pick)*LBA_W +: LBA_W];
          sd_wr   <= req_wr[pick];
          sd_rd   <= !req_wr[pick];
        end
        S_ISSUE: if (sd_ack || tmo) begin
          sd_rd <= 1'b0;
          sd_wr <= 1'b0;
        end
        S_DONE:  ptr <= gnt_idx;
        default: ;
      endcase
    end
  end

  always_comb begin
    done    = '0;
    buff_we = '0;
    if (state == S_DONE)
      done[gnt_idx] = 1'b1;
    if (state == S_XFER)
      buff_we[gnt_idx] = sd_buff_wr;
  end

  assign busy        = (state == S_ISSUE) || (state == S_XFER) || (state == S_DONE);
  assign sd_buff_din = req_din[int'(gnt_idx)*8 +: 8];

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb/tb_sd_sector_arbiter.sv - scoreboard bench for sd_sector_arbiter
module tb_sd_sector_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_rd, req_wr;
  logic [63:0] req_lba;
  logic [15:0] req_din;
  logic [1:0]  done;
  logic        err, busy;
  logic [0:0]  gnt_idx;
  logic [1:0]  buff_we;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_din;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int idx;
    bit err;
  } exp_t;
  exp_t sb[$];

  sd_sector_arbiter #(.NREQ(2), .LBA_W(32), .TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
    .req_lba(req_lba), .req_din(req_din), .done(done), .err(err),
    .busy(busy), .gnt_idx(gnt_idx), .buff_we(buff_we), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!reset && done !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_done", 32'(done), 32'(1 << e.idx));
        check("sb_err", 32'(err), 32'(e.err));
        check("sb_gnt", 32'(gnt_idx), 32'(e.idx));
      end
    end
  end

  task automatic wait_strobe(output int n);
    n = 0;
    @(negedge clk);
    while (!(sd_rd || sd_wr) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("strobe_seen", 32'(n < 50), 32'h1);
  endtask

  task automatic serve(input int idx, input bit wr, input logic [31:0] lba, input int nbytes,
                       input logic [7:0] din, input bit drop, input bit chg,
                       input logic [31:0] new_lba, output int lat);
    int bad;
    wait_strobe(lat);
    check("dir_wr", 32'(sd_wr), 32'(wr));
    check("dir_rd", 32'(sd_rd), 32'(!wr));
    check("issue_lba", sd_lba, lba);
    check("issue_gnt", 32'(gnt_idx), 32'(idx));
    check("issue_busy", 32'(busy), 32'h1);
    if (chg) req_lba[idx*32 +: 32] = new_lba;
    repeat (3) @(posedge clk);
    #1 sd_ack = 1'b1;
    @(negedge clk);
    check("strobe_before_ack_seen", 32'(sd_rd | sd_wr), 32'h1);
    @(negedge clk);
    check("strobe_drop_on_ack", 32'(sd_rd | sd_wr), 32'h0);
    check("lba_latched", sd_lba, lba);
    bad = 0;
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk);
      #1 sd_buff_wr = !wr && i[0];
      @(negedge clk);
      if (buff_we !== (sd_buff_wr ? 2'(1 << idx) : 2'b00)) bad++;
      if (sd_buff_din !== din) bad++;
    end
    check("xfer_steering_errors", 32'(bad), 32'h0);
    @(posedge clk);
    #1 begin sd_buff_wr = 1'b0; sd_ack = 1'b0; end
    @(negedge clk);
    check("done_not_early", 32'(done), 32'h0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'(1 << idx));
    check("done_busy", 32'(busy), 32'h1);
    if (drop) begin
      req_rd[idx] = 1'b0;
      req_wr[idx] = 1'b0;
    end
    @(negedge clk);
    check("gap_busy", 32'(busy), 32'h0);
    check("gap_strobe", 32'(sd_rd | sd_wr), 32'h0);
    check("gap_done", 32'(done), 32'h0);
  endtask

  initial begin
    int lat, bad, cnt;
    reset = 1'b1; req_rd = '0; req_wr = '0; req_lba = '0; req_din = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_gnt", 32'(gnt_idx), 32'h0);
    check("rst_strobes", 32'({sd_rd, sd_wr}), 32'h0);
    check("rst_lba", sd_lba, 32'h0);
    check("rst_buff_we", 32'(buff_we), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Simultaneous r0 read and r1 write; r0 keeps its request across done.
    @(posedge clk);
    #1 begin
      req_lba = {32'h2000_0001, 32'h0000_0010};
      req_din = {8'hA5, 8'h3C};
      req_rd  = 2'b01;
      req_wr  = 2'b10;
    end
    sb.push_back('{0, 1'b0});
    sb.push_back('{1, 1'b0});
    sb.push_back('{0, 1'b0});
    serve(0, 1'b0, 32'h10, 512, 8'h3C, 1'b0, 1'b1, 32'h44, lat);
    check("first_latency", 32'(lat), 32'h1);
    serve(1, 1'b1, 32'h2000_0001, 8, 8'hA5, 1'b1, 1'b0, 32'h0, lat);
    serve(0, 1'b0, 32'h44, 4, 8'h3C, 1'b1, 1'b0, 32'h0, lat);

    // Reset during XFER, then stale ack holds off the pending request.
    @(posedge clk);
    #1 begin req_lba[63:32] = 32'h99; req_rd = 2'b10; end
    wait_strobe(lat);
    repeat (3) @(posedge clk);
    #1 sd_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 sd_buff_wr = 1'b1;
    @(negedge clk);
    check("xfer_buff_we_r1", 32'(buff_we), 32'h2);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_xfer_strobe", 32'(sd_rd | sd_wr), 32'h0);
    check("rst_xfer_done", 32'(done), 32'h0);
    check("rst_xfer_buff_we", 32'(buff_we), 32'h0);
    sd_buff_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (sd_rd || sd_wr || busy || done != 2'b00) bad++;
    end
    check("stale_ack_hold", 32'(bad), 32'h0);
    @(posedge clk);
    #1 sd_ack = 1'b0;
    sb.push_back('{1, 1'b0});
    serve(1, 1'b0, 32'h99, 4, 8'hA5, 1'b1, 1'b0, 32'h0, lat);

    // Unanswered read.
    @(posedge clk);
    #1 begin req_lba[31:0] = 32'h5; req_rd = 2'b01; end
`ifdef SD_ARB_TIMEOUT_EN
    sb.push_back('{0, 1'b1});
    wait_strobe(lat);
    cnt = 0;
    while (sd_rd && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", 32'(cnt), 32'd100);
    check("timeout_done", 32'(done), 32'h1);
    check("timeout_err", 32'(err), 32'h1);
    req_rd = 2'b00;
    @(negedge clk);
    check("timeout_gap_busy", 32'(busy), 32'h0);
`else
    sb.push_back('{0, 1'b0});
    wait_strobe(lat);
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (!sd_rd || done != 2'b00) bad++;
    end
    check("no_timeout_hold", 32'(bad), 32'h0);
    serve(0, 1'b0, 32'h5, 4, 8'h3C, 1'b1, 1'b0, 32'h0, lat);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
